// File: rtl/decode_stage.sv
// decode_stage: registered, valid/ready instruction-decode stage between fetch and execute.
// Define DECODE_SKID_EN for a two-entry (output + skid) buffer with a registered in_ready.
module decode_stage #(
   parameter int WIDTH  = 16,
   parameter int DATA_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [15:0]      inst,
   input  logic [DATA_W-1:0] data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [6:0]       op,
   output logic             src_imm,
   output logic             src_ram,
   output logic [3:0]       cond,
   output logic [WIDTH-1:0] rhs,
   output logic             illegal
);

   generate
      if (WIDTH < 16) begin : g_bad_width
         $error("decode_stage: WIDTH must be >= 16");
      end
      if (DATA_W != 8) begin : g_bad_data_w
         $error("decode_stage: DATA_W must be 8");
      end
   endgenerate

   localparam logic [6:0] OP_NOP    = 7'b0000001;
   localparam logic [6:0] OP_LOAD   = 7'b0000010;
   localparam logic [6:0] OP_STORE  = 7'b0000100;
   localparam logic [6:0] OP_ADD    = 7'b0001000;
   localparam logic [6:0] OP_BRANCH = 7'b0010000;
   localparam logic [6:0] OP_IF     = 7'b0100000;
   localparam logic [6:0] OP_OUT_LO = 7'b1000000;

   typedef struct packed {
      logic [6:0]       op;
      logic             src_imm;
      logic             src_ram;
      logic [3:0]       cond;
      logic [WIDTH-1:0] rhs;
      logic             illegal;
   } entry_t;

   // An illegal encoding decodes to an all-zero entry with only the illegal flag set.
   function automatic entry_t decode_fn(input logic [15:0] i, input logic [DATA_W-1:0] d);
      entry_t     e;
      logic [15:0] sel_rhs;
      logic        sel_bad;
      e       = '0;
      sel_bad = 1'b0;
      case (i[10:8])
         3'd0, 3'd4: sel_rhs = {8'h00, i[7:0]};
         3'd1:       sel_rhs = {i[7:0], 8'h00};
         3'd2:       sel_rhs = {8'h00, d};
         3'd3:       sel_rhs = {d, 8'h00};
         default: begin
            sel_rhs = 16'h0000;
            sel_bad = 1'b1;
         end
      endcase
      if (!i[15]) begin
         if (i[15:8] == 8'h00) begin
            e.op  = OP_NOP;
            e.rhs = WIDTH'(sel_rhs);
         end else if (i[15:8] == 8'h08) begin
            e.op  = OP_OUT_LO;
            e.rhs = WIDTH'(sel_rhs);
         end else begin
            e.illegal = 1'b1;
         end
      end else begin
         case (i[15:11])
            5'b10000, 5'b10001, 5'b10010: begin
               if (sel_bad) begin
                  e.illegal = 1'b1;
               end else begin
                  e.op      = i[12] ? OP_STORE : (i[11] ? OP_ADD : OP_LOAD);
                  e.src_imm = !i[10];
                  e.src_ram = i[10];
                  e.rhs     = WIDTH'(sel_rhs);
               end
            end
            5'b11000: begin
               e.op  = OP_BRANCH;
               e.rhs = {{(WIDTH-11){i[10]}}, i[10:0]};
            end
            5'b11110: begin
               e.op  = OP_IF;
               e.rhs = WIDTH'(sel_rhs);
               case (i[10:0])
                  11'd0:   e.cond = 4'b0001;
                  11'd1:   e.cond = 4'b0010;
                  11'd2:   e.cond = 4'b0100;
                  11'd3:   e.cond = 4'b1000;
                  default: e = '{op: 7'd0, src_imm: 1'b0, src_ram: 1'b0, cond: 4'd0,
                                 rhs: '0, illegal: 1'b1};
               endcase
            end
            default: e.illegal = 1'b1;
         endcase
      end
      return e;
   endfunction

   entry_t dec_s;
   entry_t out_r;
   logic   out_valid_r;
   logic   in_xfer_s;

   assign dec_s = decode_fn(inst, data);

`ifdef DECODE_SKID_EN
   entry_t skid_r;
   logic   skid_valid_r;
   logic   in_ready_r;
   entry_t out_nxt_s;
   entry_t skid_nxt_s;
   logic   out_valid_nxt_s;
   logic   skid_valid_nxt_s;

   assign in_ready  = in_ready_r & !flush;
   assign in_xfer_s = in_valid & in_ready;

   // Next state of the two entries; a held skid entry always drains ahead of new input.
   always_comb begin
      out_nxt_s        = out_r;
      out_valid_nxt_s  = out_valid_r;
      skid_nxt_s       = skid_r;
      skid_valid_nxt_s = skid_valid_r;
      if (flush) begin
         out_nxt_s        = '0;
         out_valid_nxt_s  = 1'b0;
         skid_nxt_s       = '0;
         skid_valid_nxt_s = 1'b0;
      end else if (!out_valid_r || out_ready) begin
         if (skid_valid_r) begin
            out_nxt_s        = skid_r;
            out_valid_nxt_s  = 1'b1;
            skid_nxt_s       = '0;
            skid_valid_nxt_s = 1'b0;
         end else if (in_xfer_s) begin
            out_nxt_s       = dec_s;
            out_valid_nxt_s = 1'b1;
         end else begin
            out_nxt_s       = '0;
            out_valid_nxt_s = 1'b0;
         end
      end else if (in_xfer_s) begin
         skid_nxt_s       = dec_s;
         skid_valid_nxt_s = 1'b1;
      end else begin
         skid_valid_nxt_s = skid_valid_r;
      end
   end

   // Entry registers; in_ready is registered as "skid will be empty".
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_r        <= '0;
         out_valid_r  <= 1'b0;
         skid_r       <= '0;
         skid_valid_r <= 1'b0;
         in_ready_r   <= 1'b1;
      end else begin
         out_r        <= out_nxt_s;
         out_valid_r  <= out_valid_nxt_s;
         skid_r       <= skid_nxt_s;
         skid_valid_r <= skid_valid_nxt_s;
         in_ready_r   <= !skid_valid_nxt_s;
      end
   end
`else
   logic out_xfer_s;

   assign in_ready   = !flush & (!out_valid_r | out_ready);
   assign in_xfer_s  = in_valid & in_ready;
   assign out_xfer_s = out_valid_r & out_ready;

   // Single output register; fields are zeroed whenever the entry is empty.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_r       <= '0;
         out_valid_r <= 1'b0;
      end else if (flush) begin
         out_r       <= '0;
         out_valid_r <= 1'b0;
      end else if (in_xfer_s) begin
         out_r       <= dec_s;
         out_valid_r <= 1'b1;
      end else if (out_xfer_s) begin
         out_r       <= '0;
         out_valid_r <= 1'b0;
      end
   end
`endif

   assign out_valid = out_valid_r;
   assign op        = out_r.op;
   assign src_imm   = out_r.src_imm;
   assign src_ram   = out_r.src_ram;
   assign cond      = out_r.cond;
   assign rhs       = out_r.rhs;
   assign illegal   = out_r.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: table-driven decode vectors plus hand sequences for reset, stall, order and flush.
module tb_decode_stage;
   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rst, flush, in_valid, in_ready, out_valid, out_ready;
   logic          src_imm, src_ram, illegal;
   logic [15:0]   inst;
   logic [7:0]    data;
   logic [6:0]    op;
   logic [3:0]    cond;
   logic [W-1:0]  rhs;
   int            n_tests = 0;
   int            n_fail  = 0;

   always #5 clk = ~clk;

   decode_stage #(.WIDTH(W), .DATA_W(8)) dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .inst(inst), .data(data), .out_valid(out_valid), .out_ready(out_ready),
      .op(op), .src_imm(src_imm), .src_ram(src_ram), .cond(cond), .rhs(rhs),
      .illegal(illegal)
   );

   typedef struct {
      logic [15:0]  inst;
      logic [7:0]   data;
      logic [6:0]   op;
      logic         si;
      logic         sr;
      logic [3:0]   cond;
      logic [W-1:0] rhs;
      logic         ill;
   } vec_t;

   vec_t vecs[$];

   localparam logic [6:0] NOP = 7'b0000001, LD = 7'b0000010, ST = 7'b0000100, ADD = 7'b0001000;
   localparam logic [6:0] BR  = 7'b0010000, IFO = 7'b0100000, OLO = 7'b1000000;

   function automatic logic [63:0] outs();
      return {17'h0, out_valid, op, src_imm, src_ram, cond, illegal, rhs};
   endfunction

   function automatic logic [63:0] exp_of(input vec_t v);
      return {17'h0, 1'b1, v.op, v.si, v.sr, v.cond, v.ill, v.rhs};
   endfunction

   task automatic add(input logic [15:0] i, input logic [7:0] d, input logic [6:0] o,
                      input logic si, input logic sr, input logic [3:0] c,
                      input logic [W-1:0] r, input logic il);
      vec_t v;
      v = '{inst: i, data: d, op: o, si: si, sr: sr, cond: c, rhs: r, ill: il};
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic idle(input int n);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      flush     = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   logic [15:0]  b_inst [4] = '{16'h8011, 16'h8022, 16'h8033, 16'h8044};
   logic [W-1:0] b_rhs  [4] = '{32'h11, 32'h22, 32'h33, 32'h44};

   initial begin
      int in_idx, out_idx, cyc, extra;
      logic exp_r1, exp_v2;
`ifdef DECODE_SKID_EN
      exp_r1 = 1'b1;
      exp_v2 = 1'b1;
`else
      exp_r1 = 1'b0;
      exp_v2 = 1'b0;
`endif
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      inst = 16'h0000; data = 8'h00;

      add(16'h8105, 8'h00, LD,  1'b1, 1'b0, 4'b0000, 32'h0000_0500, 1'b0);
      add(16'hC7FF, 8'h00, BR,  1'b0, 1'b0, 4'b0000, 32'hFFFF_FFFF, 1'b0);
      add(16'hC3FF, 8'h00, BR,  1'b0, 1'b0, 4'b0000, 32'h0000_03FF, 1'b0);
      add(16'h8302, 8'hA5, LD,  1'b1, 1'b0, 4'b0000, 32'h0000_A500, 1'b0);
      add(16'h8500, 8'h00, 7'd0, 1'b0, 1'b0, 4'b0000, 32'h0, 1'b1);
      add(16'hF005, 8'h00, 7'd0, 1'b0, 1'b0, 4'b0000, 32'h0, 1'b1);
      add(16'h8A7E, 8'h33, ADD, 1'b1, 1'b0, 4'b0000, 32'h0000_0033, 1'b0);
      add(16'h9412, 8'h77, ST,  1'b0, 1'b1, 4'b0000, 32'h0000_0012, 1'b0);
      add(16'h9C12, 8'h00, 7'd0, 1'b0, 1'b0, 4'b0000, 32'h0, 1'b1);
      add(16'h91C3, 8'h5A, ST,  1'b1, 1'b0, 4'b0000, 32'h0000_C300, 1'b0);
      add(16'hF000, 8'h00, IFO, 1'b0, 1'b0, 4'b0001, 32'h0, 1'b0);
      add(16'hF001, 8'h00, IFO, 1'b0, 1'b0, 4'b0010, 32'h1, 1'b0);
      add(16'hF002, 8'h00, IFO, 1'b0, 1'b0, 4'b0100, 32'h2, 1'b0);
      add(16'hF003, 8'h00, IFO, 1'b0, 1'b0, 4'b1000, 32'h3, 1'b0);
      add(16'h0042, 8'h00, NOP, 1'b0, 1'b0, 4'b0000, 32'h42, 1'b0);
      add(16'h08FF, 8'h00, OLO, 1'b0, 1'b0, 4'b0000, 32'hFF, 1'b0);
      add(16'h0142, 8'h00, 7'd0, 1'b0, 1'b0, 4'b0000, 32'h0, 1'b1);
      add(16'hA000, 8'h00, 7'd0, 1'b0, 1'b0, 4'b0000, 32'h0, 1'b1);
      add(16'h8700, 8'h00, 7'd0, 1'b0, 1'b0, 4'b0000, 32'h0, 1'b1);
      add(16'hF801, 8'h00, 7'd0, 1'b0, 1'b0, 4'b0000, 32'h0, 1'b1);
      add(16'hC400, 8'h00, BR,  1'b0, 1'b0, 4'b0000, 32'hFFFF_FC00, 1'b0);
      add(16'h8BC3, 8'h00, ADD, 1'b1, 1'b0, 4'b0000, 32'h0, 1'b0);

      // Reset state and release
      repeat (2) @(negedge clk);
      #1 check("reset_outs", outs(), 64'h0);
      rst = 1'b0;
      #1 check("reset_in_ready", {63'h0, in_ready}, 64'h1);

      // Decode table, streamed back-to-back with out_ready held high
      out_ready = 1'b1;
      for (int i = 0; i <= vecs.size(); i++) begin
         @(negedge clk);
         if (i > 0) check($sformatf("vec%0d_%h", i - 1, vecs[i-1].inst), outs(), exp_of(vecs[i-1]));
         if (i < vecs.size()) begin
            in_valid = 1'b1;
            inst     = vecs[i].inst;
            data     = vecs[i].data;
         end else begin
            in_valid = 1'b0;
         end
      end
      idle(2);
      check("drained_empty", outs(), 64'h0);

      // Four back-to-back entries with out_ready toggling 1,0,1,0
      in_idx = 0; out_idx = 0; cyc = 0; data = 8'h00;
      while (out_idx < 4 && cyc < 40) begin
         @(negedge clk);
         out_ready = (cyc % 2 == 0);
         in_valid  = (in_idx < 4);
         inst      = (in_idx < 4) ? b_inst[in_idx] : 16'h0000;
         #1;
         if (out_valid && out_ready) begin
            check($sformatf("b2b_out%0d", out_idx), {25'h0, op, rhs}, {25'h0, LD, b_rhs[out_idx]});
            out_idx++;
         end
         if (in_valid && in_ready) in_idx++;
         cyc++;
      end
      check("b2b_count", 64'(out_idx), 64'd4);
      in_valid = 1'b0; out_ready = 1'b1; extra = 0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         #1 if (out_valid) extra++;
      end
      check("b2b_no_dup", 64'(extra), 64'd0);

      // Stall: in_ready with one and two entries held, output held stable
      @(negedge clk);
      out_ready = 1'b0; in_valid = 1'b1; inst = 16'h8001;
      #1 check("ready_empty", {63'h0, in_ready}, 64'h1);
      @(negedge clk);
      inst = 16'h8002;
      #1 check("ready_one_held", {63'h0, in_ready}, {63'h0, exp_r1});
      @(negedge clk);
      inst = 16'h8003;
      #1 check("ready_two_held", {63'h0, in_ready}, 64'h0);
      check("stall_hold", {32'h0, rhs}, 64'h1);
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
      #1 check("stall_first_out", {31'h0, out_valid, rhs}, {31'h0, 1'b1, 32'h1});
      @(negedge clk);
      #1 check("stall_second_out", {31'h0, out_valid, rhs}, {31'h0, exp_v2, exp_v2 ? 32'h2 : 32'h0});
      idle(2);

      // Flush with out_valid=1 and in_valid=1: no transfer, entry cleared
      out_ready = 1'b0; in_valid = 1'b1; inst = 16'h8105;
      @(negedge clk);
      in_valid = 1'b1; inst = 16'hC3FF; flush = 1'b1;
      #1 check("flush_ready_low", {62'h0, out_valid, in_ready}, {62'h0, 1'b1, 1'b0});
      @(negedge clk);
      flush = 1'b0; in_valid = 1'b0;
      #1 check("flush_cleared", outs(), 64'h0);
      @(negedge clk);
      #1 check("flush_no_transfer", outs(), 64'h0);

      // Flush with out_ready=1 in the same cycle, after filling both entries
      out_ready = 1'b0; in_valid = 1'b1; inst = 16'h8011;
      @(negedge clk);
      inst = 16'h8022;
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1; flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      #1 check("flush_consumed", {62'h0, out_valid, in_ready}, {62'h0, 1'b0, 1'b1});
      @(negedge clk);
      #1 check("flush_skid_empty", outs(), 64'h0);

      // Asynchronous reset mid-stream
      out_ready = 1'b0; in_valid = 1'b1; inst = 16'h8302; data = 8'hA5;
      @(negedge clk);
      in_valid = 1'b0;
      #2 rst = 1'b1;
      #1 check("rst_mid_outs", outs(), 64'h0);
      @(negedge clk);
      rst = 1'b0; out_ready = 1'b1;
      #1 check("rst_mid_ready", {63'h0, in_ready}, 64'h1);
      @(negedge clk);
      #1 check("rst_mid_lost", outs(), 64'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
